// File: rtl/wave_playback_engine.sv
// ---------------------------------------------------------------------------
// wave_playback_engine
//
// Per-DAC-channel waveform playback. The PS loads waveform words over a
// 32-bit AXIS slave while load_en=1. While idle the DAC AXIS master streams
// a locking word. A trigger rising edge plays: pre-delay zeros, N bursts of
// waveform words separated by gap zeros, post-delay zeros, then returns to
// the locking word. The first and last word of each burst can be masked.
//
// Optional feature macro: WAVE_PLAYBACK_RETRIGGER_EN
//   defined   : trigger while busy restarts the run with fresh config
//   undefined : trigger while busy is dropped and trig_overrun pulses
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   load_en               1 = load mode, 0 = playback mode
//   s_axis_*              32-bit waveform load stream (LSB-first packing)
//   trigger               run request, acts on rising edge
//   cfg_*                 run configuration, latched on accepted trigger
//   m_axis_*              DATA_W-bit DAC sample stream, registered output
//   busy                  high whenever not IDLE
//   done                  one-cycle pulse when a run completes
//   trig_overrun          one-cycle pulse when a trigger is dropped
// ---------------------------------------------------------------------------
module wave_playback_engine #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 256,
    parameter int CFG_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [31:0]       s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              trigger,
    input  logic [CFG_W-1:0]  cfg_play_words,
    input  logic [CFG_W-1:0]  cfg_bursts,
    input  logic [CFG_W-1:0]  cfg_gap,
    input  logic [CFG_W-1:0]  cfg_pre_delay,
    input  logic [CFG_W-1:0]  cfg_post_delay,
    input  logic              cfg_mask_en,
    input  logic [DATA_W-1:0] cfg_mask,
    input  logic [DATA_W-1:0] cfg_lock_word,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              busy,
    output logic              done,
    output logic              trig_overrun
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BEATS = DATA_W / 32;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CFG_W-1:0] C_ONE    = CFG_W'(1);
    localparam logic [AW:0]      LD_ONE   = (AW+1)'(1);
    localparam logic [AW:0]      LD_FULL  = (AW+1)'(DEPTH);
    localparam logic [BW-1:0]    BEAT_LST = BW'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_PLAY,
        S_GAP,
        S_POST
    } state_e;

    // ------------------------------------------------------------------
    // Waveform memory and load path
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              load_q;
    logic [AW-1:0]     wp_q;
    logic [BW-1:0]     beat_q;
    logic [AW:0]       loaded_q;
    logic [DATA_W-1:0] buf_q;

    logic              load_rise;
    logic              s_acc;
    logic [AW-1:0]     wp_b;
    logic [BW-1:0]     beat_b;
    logic [AW:0]       loaded_b;
    logic [DATA_W-1:0] wr_word;
    logic              mem_we;

    state_e            state_q, state_d;
    logic              tvalid_q;

    // tvalid_q doubles as an "out of reset" flag so the slave port stays
    // closed while rst is asserted regardless of load_en.
    assign s_axis_tready = tvalid_q & load_en & (state_q == S_IDLE) & (loaded_q < LD_FULL);
    assign s_acc         = s_axis_tready & s_axis_tvalid;
    assign load_rise     = load_en & ~load_q;

    // A load_en rising edge restarts the load from scratch; a beat arriving
    // on that same cycle becomes beat 0 of word 0.
    assign wp_b     = load_rise ? '0 : wp_q;
    assign beat_b   = load_rise ? '0 : beat_q;
    assign loaded_b = load_rise ? '0 : loaded_q;
    assign mem_we   = s_acc & (beat_b == BEAT_LST);

    always_comb begin
        wr_word = buf_q;
        wr_word[32*beat_b +: 32] = s_axis_tdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_q   <= 1'b0;
            wp_q     <= '0;
            beat_q   <= '0;
            loaded_q <= '0;
            buf_q    <= '0;
        end else begin
            load_q <= load_en;
            if (s_acc) begin
                buf_q <= wr_word;
                if (beat_b == BEAT_LST) begin
                    beat_q   <= '0;
                    wp_q     <= wp_b + 1'b1;
                    loaded_q <= loaded_b + LD_ONE;
                end else begin
                    beat_q   <= beat_b + 1'b1;
                    wp_q     <= wp_b;
                    loaded_q <= loaded_b;
                end
            end else begin
                beat_q   <= beat_b;
                wp_q     <= wp_b;
                loaded_q <= loaded_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wp_b] <= wr_word;
    end

    // ------------------------------------------------------------------
    // Playback control
    // ------------------------------------------------------------------
    logic [CFG_W-1:0]  cnt_q, cnt_d;
    logic [CFG_W-1:0]  burst_q, burst_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [CFG_W-1:0]  play_q, bursts_q, gap_q, pre_q, post_q;
    logic              mask_en_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] tdata_q, word_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic              trig_q;
    logic              cfg_ld;

    logic              trig_rise, start_ok;
    logic              first_w, last_w;
    logic [DATA_W-1:0] raw_w, play_w;
    logic [AW-1:0]     rd_nxt;

    assign trig_rise = trigger & ~trig_q;
    assign start_ok  = trig_rise & ~load_en & (cfg_play_words != '0);

    assign first_w = (cnt_q == '0);
    assign last_w  = ((cnt_q + C_ONE) == play_q);
    assign raw_w   = (loaded_q == '0) ? '0 : mem_q[rd_q];
    // With both edges masked the word becomes data & mask & ~mask = 0.
    assign play_w  = raw_w & ((mask_en_q & first_w) ? mask_q : '1)
                           & ((mask_en_q & last_w) ? ~mask_q : '1);
    assign rd_nxt  = (({1'b0, rd_q} + LD_ONE) == loaded_q) ? '0 : rd_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        rd_d    = rd_q;
        word_d  = '0;
        done_d  = 1'b0;
        ovr_d   = 1'b0;
        cfg_ld  = 1'b0;

        case (state_q)
            S_IDLE: begin
                word_d = cfg_lock_word;
                if (start_ok) begin
                    cfg_ld  = 1'b1;
                    cnt_d   = '0;
                    burst_d = '0;
                    rd_d    = '0;
                    state_d = (cfg_pre_delay != '0) ? S_PRE : S_PLAY;
                end
            end
            S_PRE: begin
                if ((cnt_q + C_ONE) == pre_q) begin
                    cnt_d   = '0;
                    rd_d    = '0;
                    state_d = S_PLAY;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            S_PLAY: begin
                word_d = play_w;
                if (last_w) begin
                    cnt_d = '0;
                    rd_d  = '0;
                    if ((burst_q + C_ONE) == bursts_q) begin
                        // A run with no post-delay still counts as completed.
                        if (post_q != '0) begin
                            state_d = S_POST;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        burst_d = burst_q + C_ONE;
                        state_d = (gap_q != '0) ? S_GAP : S_PLAY;
                    end
                end else begin
                    cnt_d = cnt_q + C_ONE;
                    rd_d  = rd_nxt;
                end
            end
            S_GAP: begin
                if ((cnt_q + C_ONE) == gap_q) begin
                    cnt_d   = '0;
                    rd_d    = '0;
                    state_d = S_PLAY;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            S_POST: begin
                if ((cnt_q + C_ONE) == post_q) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE) begin
`ifdef WAVE_PLAYBACK_RETRIGGER_EN
            if (start_ok) begin
                cfg_ld  = 1'b1;
                cnt_d   = '0;
                burst_d = '0;
                rd_d    = '0;
                done_d  = 1'b0;
                state_d = (cfg_pre_delay != '0) ? S_PRE : S_PLAY;
            end
`else
            ovr_d = trig_rise;
`endif
        end
    end

    // Everything on the playback side advances only when the DAC accepts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            burst_q   <= '0;
            rd_q      <= '0;
            play_q    <= '0;
            bursts_q  <= '0;
            gap_q     <= '0;
            pre_q     <= '0;
            post_q    <= '0;
            mask_en_q <= 1'b0;
            mask_q    <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            trig_q    <= 1'b0;
        end else begin
            tvalid_q <= 1'b1;
            if (m_axis_tready) begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                burst_q <= burst_d;
                rd_q    <= rd_d;
                tdata_q <= word_d;
                done_q  <= done_d;
                ovr_q   <= ovr_d;
                trig_q  <= trigger;
                if (cfg_ld) begin
                    play_q    <= cfg_play_words;
                    bursts_q  <= (cfg_bursts == '0) ? C_ONE : cfg_bursts;
                    gap_q     <= cfg_gap;
                    pre_q     <= cfg_pre_delay;
                    post_q    <= cfg_post_delay;
                    mask_en_q <= cfg_mask_en;
                    mask_q    <= cfg_mask;
                end
            end else begin
                done_q <= 1'b0;
                ovr_q  <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign trig_overrun  = ovr_q;

endmodule

// File: tb/tb_wave_playback_engine.sv
module tb_wave_playback_engine;

    localparam int DW = 256;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_en = 1'b0;
    logic [31:0]   s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          trigger = 1'b0;
    logic [CW-1:0] cfg_play_words = '0;
    logic [CW-1:0] cfg_bursts = '0;
    logic [CW-1:0] cfg_gap = '0;
    logic [CW-1:0] cfg_pre_delay = '0;
    logic [CW-1:0] cfg_post_delay = '0;
    logic          cfg_mask_en = 1'b0;
    logic [DW-1:0] cfg_mask = '0;
    logic [DW-1:0] cfg_lock_word = '0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          busy;
    logic          done;
    logic          trig_overrun;

    wave_playback_engine #(.DATA_W(DW), .DEPTH(256), .CFG_W(CW)) dut (
        .clk(clk), .rst(rst), .load_en(load_en),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .trigger(trigger),
        .cfg_play_words(cfg_play_words), .cfg_bursts(cfg_bursts), .cfg_gap(cfg_gap),
        .cfg_pre_delay(cfg_pre_delay), .cfg_post_delay(cfg_post_delay),
        .cfg_mask_en(cfg_mask_en), .cfg_mask(cfg_mask), .cfg_lock_word(cfg_lock_word),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .busy(busy), .done(done), .trig_overrun(trig_overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0]   pat [5] = '{16'haaaa, 16'hbbbb, 16'hcccc, 16'hdddd, 16'heeee};
    logic [DW-1:0] LOCK, MASK, ZERO;
    logic [DW-1:0] cap [64];
    logic [DW-1:0] exp_q [$];
    int            done_cnt, ovr_cnt;

    function automatic logic [DW-1:0] rep(input logic [15:0] h);
        return {16{h}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int pw, input int b, input int g, input int pre, input int post,
                           input logic men);
        cfg_play_words = pw;
        cfg_bursts     = b;
        cfg_gap        = g;
        cfg_pre_delay  = pre;
        cfg_post_delay = post;
        cfg_mask_en    = men;
    endtask

    // Raises trigger, then records m_axis_tdata after each of n clock edges.
    // retrig_at >= 0 re-raises trigger after that capture index.
    task automatic capture(input int n, input int retrig_at);
        done_cnt = 0;
        ovr_cnt  = 0;
        trigger  = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            cap[i] = m_axis_tdata;
            done_cnt += int'(done);
            ovr_cnt  += int'(trig_overrun);
            if (i == 0) trigger = 1'b0;
            if (i == retrig_at) trigger = 1'b1;
            if (i == retrig_at + 1) trigger = 1'b0;
        end
    endtask

    // Expected sequence of the main test-plan run (pre=2, 10 words, post=2).
    task automatic build_single();
        exp_q.delete();
        exp_q.push_back(LOCK);
        exp_q.push_back(ZERO);
        exp_q.push_back(ZERO);
        exp_q.push_back(rep(16'haaaa) & MASK);
        for (int i = 1; i < 9; i++) exp_q.push_back(rep(pat[i % 5]));
        exp_q.push_back(rep(16'heeee) & ~MASK);
        exp_q.push_back(ZERO);
        exp_q.push_back(ZERO);
        exp_q.push_back(LOCK);
    endtask

    task automatic test_reset();
        load_en = 1'b1;
        #2;
        total++;
        if (m_axis_tdata !== ZERO || m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || trig_overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got tdata=%h tvalid=%b sready=%b busy=%b done=%b ovr=%b want all 0",
                     m_axis_tdata, m_axis_tvalid, s_axis_tready, busy, done, trig_overrun);
        end
        load_en = 1'b0;
        step();
        rst = 1'b1;
        step();
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== LOCK) begin
            bad++;
            $display("FAIL reset_release got tvalid=%b tdata=%h want 1 / %h", m_axis_tvalid, m_axis_tdata, LOCK);
        end
    endtask

    task automatic test_ignore();
        // play_words=0: trigger ignored silently
        set_cfg(0, 1, 0, 2, 2, 1'b0);
        capture(4, -1);
        total++;
        if (busy !== 1'b0 || ovr_cnt != 0 || cap[3] !== LOCK) begin
            bad++;
            $display("FAIL ignore_zero_words got busy=%b ovr=%0d tdata=%h want 0 0 lock", busy, ovr_cnt, cap[3]);
        end
        // load mode: trigger ignored
        set_cfg(10, 1, 0, 2, 2, 1'b0);
        load_en = 1'b1;
        capture(4, -1);
        load_en = 1'b0;
        total++;
        if (busy !== 1'b0 || ovr_cnt != 0 || cap[3] !== LOCK) begin
            bad++;
            $display("FAIL ignore_load_mode got busy=%b ovr=%0d tdata=%h want 0 0 lock", busy, ovr_cnt, cap[3]);
        end
        step();
    endtask

    task automatic test_load();
        logic rdy_ok;
        rdy_ok = 1'b1;
        // partial word, discarded by the next load_en rise
        load_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_axis_tdata  = 32'h1234_5678 + k;
            s_axis_tvalid = 1'b1;
            step();
        end
        s_axis_tvalid = 1'b0;
        load_en = 1'b0;
        step();
        load_en = 1'b1;
        for (int w = 0; w < 5; w++) begin
            for (int k = 0; k < 8; k++) begin
                s_axis_tdata  = {pat[w], pat[w]};
                s_axis_tvalid = 1'b1;
                #1;
                if (s_axis_tready !== 1'b1) rdy_ok = 1'b0;
                step();
            end
        end
        s_axis_tvalid = 1'b0;
        total++;
        if (rdy_ok !== 1'b1 || s_axis_tready !== 1'b1) begin
            bad++;
            $display("FAIL load_ready got beats_ok=%b ready_after=%b want 1 1", rdy_ok, s_axis_tready);
        end
        load_en = 1'b0;
        #1;
        total++;
        if (s_axis_tready !== 1'b0) begin
            bad++;
            $display("FAIL load_ready_drop got %b want 0", s_axis_tready);
        end
        step();
    endtask

    task automatic test_single();
        set_cfg(10, 1, 0, 2, 2, 1'b1);
        build_single();
        capture(16, -1);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (cap[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL single_word[%0d] got %h want %h", i, cap[i], exp_q[i]);
            end
        end
        total++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_done got done=%0d busy=%b want 1 0", done_cnt, busy);
        end
    endtask

    task automatic test_bursts();
        logic [DW-1:0] a1, b1;
        a1 = rep(16'haaaa) & MASK;
        b1 = rep(16'hbbbb) & ~MASK;
        set_cfg(2, 3, 1, 0, 1, 1'b1);
        exp_q.delete();
        exp_q = '{LOCK, a1, b1, ZERO, a1, b1, ZERO, a1, b1, ZERO, LOCK};
        capture(11, -1);
        for (int i = 0; i < 11; i++) begin
            total++;
            if (cap[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL bursts_word[%0d] got %h want %h", i, cap[i], exp_q[i]);
            end
        end
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL bursts_done got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_bursts_zero();
        set_cfg(3, 0, 0, 0, 0, 1'b0);
        exp_q.delete();
        exp_q = '{LOCK, rep(16'haaaa), rep(16'hbbbb), rep(16'hcccc), LOCK};
        capture(5, -1);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (cap[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL bursts0_word[%0d] got %h want %h", i, cap[i], exp_q[i]);
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL bursts0_busy got %b want 0", busy);
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] got [$];
        logic [DW-1:0] last;
        logic          rdy;
        set_cfg(10, 1, 0, 2, 2, 1'b1);
        build_single();
        done_cnt = 0;
        last     = LOCK;
        trigger  = 1'b1;
        for (int c = 0; c < 19; c++) begin
            rdy = !(c >= 6 && c < 9);
            m_axis_tready = rdy;
            step();
            if (c == 0) trigger = 1'b0;
            done_cnt += int'(done);
            if (rdy) begin
                got.push_back(m_axis_tdata);
                last = m_axis_tdata;
            end else begin
                total++;
                if (m_axis_tdata !== last) begin
                    bad++;
                    $display("FAIL stall_frozen[%0d] got %h want %h", c, m_axis_tdata, last);
                end
            end
        end
        m_axis_tready = 1'b1;
        total++;
        if (got.size() != 16) begin
            bad++;
            $display("FAIL stall_count got %0d want 16", got.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                total++;
                if (got[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL stall_word[%0d] got %h want %h", i, got[i], exp_q[i]);
                end
            end
        end
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL stall_done got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_retrigger();
        set_cfg(10, 1, 0, 2, 2, 1'b1);
`ifdef WAVE_PLAYBACK_RETRIGGER_EN
        exp_q.delete();
        exp_q = '{LOCK, ZERO, ZERO, rep(16'haaaa) & MASK, rep(16'hbbbb), rep(16'hcccc), rep(16'hdddd)};
        exp_q.push_back(ZERO);
        exp_q.push_back(ZERO);
        exp_q.push_back(rep(16'haaaa) & MASK);
        for (int i = 1; i < 9; i++) exp_q.push_back(rep(pat[i % 5]));
        exp_q.push_back(rep(16'heeee) & ~MASK);
        exp_q.push_back(ZERO);
        exp_q.push_back(ZERO);
        exp_q.push_back(LOCK);
`else
        build_single();
        for (int i = 0; i < 6; i++) exp_q.push_back(LOCK);
`endif
        capture(22, 5);
        for (int i = 0; i < 22; i++) begin
            total++;
            if (cap[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL retrig_word[%0d] got %h want %h", i, cap[i], exp_q[i]);
            end
        end
        total++;
`ifdef WAVE_PLAYBACK_RETRIGGER_EN
        if (ovr_cnt != 0 || done_cnt != 1) begin
            bad++;
            $display("FAIL retrig_pulses got ovr=%0d done=%0d want 0 1", ovr_cnt, done_cnt);
        end
`else
        if (ovr_cnt != 1 || done_cnt != 1) begin
            bad++;
            $display("FAIL retrig_pulses got ovr=%0d done=%0d want 1 1", ovr_cnt, done_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        set_cfg(10, 1, 0, 2, 2, 1'b1);
        trigger = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            if (i == 0) trigger = 1'b0;
        end
        total++;
        if (busy !== 1'b1 || m_axis_tdata !== ZERO) begin
            bad++;
            $display("FAIL reset_mid_pre got busy=%b tdata=%h want 1 0", busy, m_axis_tdata);
        end
        rst = 1'b0;
        #1;
        total++;
        if (m_axis_tdata !== ZERO || m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || trig_overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_outputs got tdata=%h tvalid=%b busy=%b done=%b want all 0",
                     m_axis_tdata, m_axis_tvalid, busy, done);
        end
        step();
        rst = 1'b1;
        step();
        total++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== LOCK || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_release got tvalid=%b tdata=%h busy=%b want 1 lock 0",
                     m_axis_tvalid, m_axis_tdata, busy);
        end
    endtask

    initial begin
        LOCK = rep(16'h1111);
        MASK = {{8{16'h0000}}, {8{16'hffff}}};
        ZERO = '0;
        cfg_lock_word = LOCK;
        cfg_mask      = MASK;
        test_reset();
        test_ignore();
        test_load();
        test_single();
        test_bursts();
        test_bursts_zero();
        test_stall();
        test_retrigger();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
